// File: rtl/tile_write_queue.sv
// tile_write_queue: buffers tile-change requests in a small FIFO and drives the
// write port of the 32x24 board RAM. A clear sequencer can fill all 768 board
// entries with one tile type; queued edits are held and drain after the fill.
// Optional feature: define TILE_BOUNDS_CHECK_EN to drop requests with row >= 24
// and raise the sticky err_oob flag instead of writing them.
module tile_write_queue #(
   parameter int DEPTH = 4
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [4:0] req_x,
   input  logic [4:0] req_y,
   input  logic [3:0] req_type,
   input  logic       wr_window,
   input  logic       clear_start,
   input  logic [3:0] clear_type,
   output logic       busy,
   output logic       clear_done,
   output logic [9:0] ram_address,
   output logic [3:0] ram_data,
   output logic       ram_wren,
   output logic       err_oob
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t state, next_state;

   logic [13:0]      fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic [13:0]      head;

   logic [9:0] clear_count;
   logic [3:0] fill_type;

   logic push, store, pop, entry_ok;
   logic clear_write, clear_finish;

   assign req_ready = (fifo_count != CNT_W'(DEPTH));
   assign push      = req_valid && req_ready;
   assign store     = push && entry_ok;
   assign head      = fifo_mem[rd_ptr];

`ifdef TILE_BOUNDS_CHECK_EN
   assign entry_ok = (req_y < 5'd24);

   // Sticky flag: any accepted request with an off-board row sets it until reset
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         err_oob <= 1'b0;
      else if (push && !entry_ok)
         err_oob <= 1'b1;
   end
`else
   assign entry_ok = 1'b1;
   assign err_oob  = 1'b0;
`endif

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic: a clear runs until the counter has passed the last address
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (clear_start)  next_state = CLEAR;
         CLEAR:   if (clear_finish) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Decode per-state actions; a clear_start cycle blocks the pop so the fill goes first
   always_comb begin
      busy         = (state == CLEAR);
      pop          = (state == IDLE) && (fifo_count != '0) && wr_window && !clear_start;
      clear_write  = (state == CLEAR) && (clear_count != 10'd768) && wr_window;
      clear_finish = (state == CLEAR) && (clear_count == 10'd768);
   end

   // FIFO storage; contents need no reset because the count guards every read
   always_ff @(posedge CLOCK_50) begin
      if (store)
         fifo_mem[wr_ptr] <= {req_y, req_x, req_type};
   end

   // FIFO pointers and occupancy; a pop frees space only after its edge
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (store)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + CNT_W'(store) - CNT_W'(pop);
      end
   end

   // Clear sequencer: latch the fill type on start, advance on each window-open write
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clear_count <= '0;
         fill_type   <= '0;
      end else if (state == IDLE && clear_start) begin
         clear_count <= '0;
         fill_type   <= clear_type;
      end else if (clear_write) begin
         clear_count <= clear_count + 10'd1;
      end
   end

   // Registered RAM port; address is y*32+x, which is simply {y, x}
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         ram_wren    <= 1'b0;
         ram_address <= '0;
         ram_data    <= '0;
         clear_done  <= 1'b0;
      end else begin
         ram_wren   <= pop || clear_write;
         clear_done <= clear_finish;
         if (pop) begin
            ram_address <= {head[13:9], head[8:4]};
            ram_data    <= head[3:0];
         end else if (clear_write) begin
            ram_address <= clear_count;
            ram_data    <= fill_type;
         end
      end
   end

endmodule

// File: tb/tb_tile_write_queue.sv
// Testbench for tile_write_queue: directed scenarios plus a randomized run
// checked against a queue-based model of the request FIFO.
// Honours TILE_BOUNDS_CHECK_EN to select the expected out-of-bounds behaviour.
module tb_tile_write_queue;

   localparam int DEPTH = 4;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] req_x;
   logic [4:0] req_y;
   logic [3:0] req_type;
   logic       wr_window;
   logic       clear_start;
   logic [3:0] clear_type;
   logic       busy;
   logic       clear_done;
   logic [9:0] ram_address;
   logic [3:0] ram_data;
   logic       ram_wren;
   logic       err_oob;

   int n_checks = 0;
   int n_fail   = 0;

   tile_write_queue #(.DEPTH(DEPTH)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_type    (req_type),
      .wr_window   (wr_window),
      .clear_start (clear_start),
      .clear_type  (clear_type),
      .busy        (busy),
      .clear_done  (clear_done),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .err_oob     (err_oob)
   );

   // Free-running 100 MHz clock
   always #5 CLOCK_50 = ~CLOCK_50;

   // Advance one edge and settle; outputs are sampled 1 time unit after the edge
   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_reset;
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_x       = '0;
      req_y       = '0;
      req_type    = '0;
      wr_window   = 1'b0;
      clear_start = 1'b0;
      clear_type  = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (clear_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_clear_done: got %b expected 0", clear_done); end
      n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ram_wren: got %b expected 0", ram_wren); end
      n_checks++; if (ram_address !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_ram_address: got %0d expected 0", ram_address); end
      n_checks++; if (ram_data !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_ram_data: got %0d expected 0", ram_data); end
      n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err_oob: got %b expected 0", err_oob); end
   endtask

   task automatic test_single_write;
      do_reset();
      wr_window = 1'b1;
      req_valid = 1'b1; req_x = 5'd5; req_y = 5'd3; req_type = 4'd2;
      tick();
      req_valid = 1'b0;
      n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL single_no_fallthrough: ram_wren got %b expected 0", ram_wren); end
      tick();
      n_checks++; if (ram_wren !== 1'b1) begin n_fail++; $display("[TB] FAIL single_wren: got %b expected 1", ram_wren); end
      n_checks++; if (ram_address !== 10'd101) begin n_fail++; $display("[TB] FAIL single_address: got %0d expected 101", ram_address); end
      n_checks++; if (ram_data !== 4'd2) begin n_fail++; $display("[TB] FAIL single_data: got %0d expected 2", ram_data); end
      tick();
      n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL single_one_cycle: ram_wren got %b expected 0", ram_wren); end
      n_checks++; if (ram_address !== 10'd101) begin n_fail++; $display("[TB] FAIL single_hold: ram_address got %0d expected 101", ram_address); end
   endtask

   task automatic test_backpressure;
      logic [4:0] xs [5];
      logic [4:0] ys [5];
      logic [3:0] ts [5];
      int nw;
      int first_cyc;
      int last_cyc;
      int bad;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         xs[i] = 5'($urandom_range(0, 31));
         ys[i] = 5'($urandom_range(0, 23));
         ts[i] = 4'($urandom_range(0, 15));
      end
      wr_window = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_x = xs[i]; req_y = ys[i]; req_type = ts[i];
         n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_before_%0d: got %b expected 1", i, req_ready); end
         tick();
      end
      req_x = xs[4]; req_y = ys[4]; req_type = ts[4];
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full: req_ready got %b expected 0", req_ready); end
      n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_closed_window: ram_wren got %b expected 0", ram_wren); end
      wr_window = 1'b1;
      nw = 0; bad = 0; first_cyc = -1; last_cyc = -1;
      for (int cyc = 0; cyc < 30 && nw < 5; cyc++) begin
         automatic logic accepted = req_valid && req_ready;
         tick();
         if (accepted) req_valid = 1'b0;
         if (ram_wren) begin
            if (ram_address !== 10'(int'(ys[nw]) * 32 + int'(xs[nw])) || ram_data !== ts[nw]) bad++;
            if (nw == 0) first_cyc = cyc;
            last_cyc = cyc;
            nw++;
         end
      end
      req_valid = 1'b0;
      n_checks++; if (nw !== 5) begin n_fail++; $display("[TB] FAIL bp_write_count: got %0d expected 5", nw); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL bp_order: %0d writes wrong, expected 0", bad); end
      n_checks++; if (last_cyc - first_cyc !== 4) begin n_fail++; $display("[TB] FAIL bp_consecutive: span %0d cycles expected 4", last_cyc - first_cyc); end
   endtask

   task automatic test_clear_pauses;
      int next_addr;
      int bad;
      int done_cyc;
      int last_write_cyc;
      int extra_pulses;
      logic prev_win;
      logic busy_at_done;
      do_reset();
      clear_type = 4'd1; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_busy_rise: got %b expected 1", busy); end
      next_addr = 0; bad = 0; done_cyc = -1; last_write_cyc = -10; busy_at_done = 1'b1;
      for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
         wr_window = (cyc % 2 == 1);
         prev_win  = wr_window;
         tick();
         if (clear_done) begin
            done_cyc = cyc;
            busy_at_done = busy;
         end else if (busy !== 1'b1) begin
            bad++;
         end
         if (ram_wren) begin
            if (ram_address !== 10'(next_addr) || ram_data !== 4'd1 || !prev_win) bad++;
            if (next_addr == 767) last_write_cyc = cyc;
            next_addr++;
         end else if (prev_win && next_addr < 768) begin
            bad++;
         end
      end
      wr_window = 1'b0;
      extra_pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (clear_done || busy) extra_pulses++;
      end
      n_checks++; if (done_cyc < 0) begin n_fail++; $display("[TB] FAIL clear_timeout: clear_done never seen, %0d writes", next_addr); end
      n_checks++; if (next_addr !== 768) begin n_fail++; $display("[TB] FAIL clear_write_count: got %0d expected 768", next_addr); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL clear_sequence: %0d bad cycles, expected 0", bad); end
      n_checks++; if (done_cyc !== last_write_cyc + 1) begin n_fail++; $display("[TB] FAIL clear_done_timing: cycle %0d expected %0d", done_cyc, last_write_cyc + 1); end
      n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_busy_fall: busy got %b expected 0 with clear_done", busy_at_done); end
      n_checks++; if (extra_pulses !== 0) begin n_fail++; $display("[TB] FAIL clear_single_pulse: %0d extra cycles with done/busy, expected 0", extra_pulses); end
   endtask

   task automatic test_clear_vs_queue;
      logic [9:0] wa [$];
      logic [3:0] wd [$];
      int done_at;
      int bad;
      do_reset();
      req_valid = 1'b1; req_x = 5'd7; req_y = 5'd2; req_type = 4'd3;
      tick();
      req_x = 5'd31; req_y = 5'd23; req_type = 4'd9;
      tick();
      req_valid = 1'b0;
      wr_window = 1'b1; clear_type = 4'd6; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL cvq_no_pop: ram_wren got %b expected 0", ram_wren); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL cvq_busy: got %b expected 1", busy); end
      done_at = -1;
      for (int cyc = 0; cyc < 1000 && wa.size() < 770; cyc++) begin
         tick();
         if (clear_done) done_at = wa.size();
         if (ram_wren) begin
            wa.push_back(ram_address);
            wd.push_back(ram_data);
         end
      end
      n_checks++; if (wa.size() !== 770) begin n_fail++; $display("[TB] FAIL cvq_write_count: got %0d expected 770", wa.size()); end
      n_checks++; if (done_at !== 768) begin n_fail++; $display("[TB] FAIL cvq_done_position: after %0d writes expected 768", done_at); end
      bad = 0;
      for (int i = 0; i < 768 && i < wa.size(); i++)
         if (wa[i] !== 10'(i) || wd[i] !== 4'd6) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL cvq_fill: %0d bad fill writes expected 0", bad); end
      if (wa.size() == 770) begin
         n_checks++; if (wa[768] !== 10'd71 || wd[768] !== 4'd3) begin n_fail++; $display("[TB] FAIL cvq_first_edit: got %0d/%0d expected 71/3", wa[768], wd[768]); end
         n_checks++; if (wa[769] !== 10'd767 || wd[769] !== 4'd9) begin n_fail++; $display("[TB] FAIL cvq_second_edit: got %0d/%0d expected 767/9", wa[769], wd[769]); end
      end
   endtask

   task automatic test_reset_mid_clear;
      logic found;
      int late_writes;
      do_reset();
      req_valid = 1'b1; req_x = 5'd1; req_y = 5'd1; req_type = 4'd4;
      tick();
      req_valid = 1'b0;
      wr_window = 1'b1; clear_type = 4'd2; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      found = 1'b0;
      for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
         tick();
         if (ram_wren && ram_address == 10'd300) found = 1'b1;
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL rmc_reach_300: got %b expected 1", found); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL rmc_wren: got %b expected 0", ram_wren); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rmc_busy: got %b expected 0", busy); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmc_ready: got %b expected 1", req_ready); end
      n_checks++; if (ram_address !== 10'd0) begin n_fail++; $display("[TB] FAIL rmc_address: got %0d expected 0", ram_address); end
      late_writes = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ram_wren || clear_done) late_writes++;
      end
      n_checks++; if (late_writes !== 0) begin n_fail++; $display("[TB] FAIL rmc_no_writes: got %0d writes expected 0", late_writes); end
   endtask

   task automatic test_oob;
      int nw;
      logic [9:0] last_addr;
      logic [3:0] last_data;
      do_reset();
      wr_window = 1'b1;
      req_valid = 1'b1; req_x = 5'd3; req_y = 5'd24; req_type = 4'd5;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_handshake: req_ready got %b expected 1", req_ready); end
      tick();
      req_valid = 1'b0;
      nw = 0; last_addr = '0; last_data = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ram_wren) begin
            nw++;
            last_addr = ram_address;
            last_data = ram_data;
         end
      end
`ifdef TILE_BOUNDS_CHECK_EN
      n_checks++; if (nw !== 0) begin n_fail++; $display("[TB] FAIL oob_dropped: got %0d writes expected 0", nw); end
      n_checks++; if (err_oob !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_flag: got %b expected 1", err_oob); end
      req_valid = 1'b1; req_y = 5'd4;
      tick();
      req_valid = 1'b0;
      tick();
      n_checks++; if (err_oob !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_sticky: got %b expected 1", err_oob); end
`else
      n_checks++; if (nw !== 1) begin n_fail++; $display("[TB] FAIL oob_write_count: got %0d expected 1", nw); end
      n_checks++; if (last_addr !== 10'd771 || last_data !== 4'd5) begin n_fail++; $display("[TB] FAIL oob_write: got %0d/%0d expected 771/5", last_addr, last_data); end
      n_checks++; if (err_oob !== 1'b0) begin n_fail++; $display("[TB] FAIL oob_flag: got %b expected 0", err_oob); end
`endif
   endtask

   // Random traffic in IDLE: model is a queue of pending edits drained in order
   task automatic test_random;
      logic [13:0] model_q [$];
      logic [13:0] entry;
      logic exp_ready;
      logic do_push;
      logic do_pop;
      int bad_ready;
      int bad_write;
      do_reset();
      bad_ready = 0; bad_write = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         req_valid = ($urandom_range(0, 99) < 60);
         req_x     = 5'($urandom_range(0, 31));
         req_y     = 5'($urandom_range(0, 23));
         req_type  = 4'($urandom_range(0, 15));
         wr_window = ($urandom_range(0, 99) < 45);
         #1;
         exp_ready = (model_q.size() < DEPTH);
         if (req_ready !== exp_ready) bad_ready++;
         do_push = req_valid && exp_ready;
         do_pop  = (model_q.size() > 0) && wr_window;
         entry   = {req_y, req_x, req_type};
         tick();
         if (do_pop) begin
            if (ram_wren !== 1'b1
                || ram_address !== 10'(int'(model_q[0][13:9]) * 32 + int'(model_q[0][8:4]))
                || ram_data !== model_q[0][3:0]) bad_write++;
            void'(model_q.pop_front());
         end else if (ram_wren !== 1'b0) begin
            bad_write++;
         end
         if (do_push) model_q.push_back(entry);
      end
      req_valid = 1'b0;
      n_checks++; if (bad_ready !== 0) begin n_fail++; $display("[TB] FAIL rand_ready: %0d cycles wrong expected 0", bad_ready); end
      n_checks++; if (bad_write !== 0) begin n_fail++; $display("[TB] FAIL rand_writes: %0d cycles wrong expected 0", bad_write); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_backpressure();
      test_clear_pauses();
      test_clear_vs_queue();
      test_reset_mid_clear();
      test_oob();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
